// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural integer register file for the 5-stage RISC-V pipeline.
// The writeback stage writes through one port. Decode reads two source operands
// combinationally through two read ports. A write-through bypass makes a
// writeback visible to decode in the same cycle, so there is no pipeline bubble.
// A registered copy of x10 (a0) is exported for observation. A saturating
// counter records the number of committed architectural writes.
//
// Parameters
//   D_WIDTH      data width of each register
//   A_WIDTH      register address width; depth = 2**A_WIDTH (must be >= 4 so
//                that x10 exists)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst_n        synchronous, active-low reset
//   reg_write_w  write enable from writeback
//   rd_w         destination register address from writeback
//   result_w     data to write
//   rs1_d        source 1 address from decode
//   rs2_d        source 2 address from decode
//   rd1_d        source 1 data (combinational, bypassed)
//   rd2_d        source 2 data (combinational, bypassed)
//   a0           registered value of x10 (post-write value)
//   write_count  committed writes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module register_file #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               reg_write_w,
  input  logic [A_WIDTH-1:0] rd_w,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic [A_WIDTH-1:0] rs1_d,
  input  logic [A_WIDTH-1:0] rs2_d,
  output logic [D_WIDTH-1:0] rd1_d,
  output logic [D_WIDTH-1:0] rd2_d,
  output logic [D_WIDTH-1:0] a0,
  output logic [15:0]        write_count
);

  localparam int                 DEPTH     = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] A0_IDX    = A_WIDTH'(10);
  localparam logic [15:0]        CNT_MAX   = 16'hFFFF;

  logic [D_WIDTH-1:0] r_regs [DEPTH];
  logic [D_WIDTH-1:0] r_a0;
  logic [15:0]        r_write_count;

  // A write commits only when it targets a real register. x0 is hard-wired to
  // zero, so a write to it is dropped and is not counted.
  logic w_write_en;
  logic w_write_a0;
  logic w_cnt_sat;

  assign w_write_en = reg_write_w && (rd_w != '0);
  assign w_write_a0 = w_write_en && (rd_w == A0_IDX);
  assign w_cnt_sat  = (r_write_count == CNT_MAX);

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: the storage is a flip-flop array, not a RAM macro. Resetting every
  // entry costs nothing, and it gives the required all-zero state after reset.
  // A RAM-backed file could not be cleared in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_en) begin
      // NOTE: sequential state is assigned with <= only. The a0 tap and the
      // counter are updated in other blocks, and they sample the pre-edge
      // array. With <= that sampling is free of races.
      r_regs[rd_w] <= result_w;
    end
  end

  // ---------------------------------------------------------------------------
  // a0 tap: holds the post-write value of x10. On a write to x10, take the
  // incoming data directly so that a0 changes on the same edge as the array.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a0 <= '0;
    end else if (w_write_a0) begin
      r_a0 <= result_w;
    end else begin
      r_a0 <= r_regs[A0_IDX];
    end
  end

  // ---------------------------------------------------------------------------
  // Committed-write counter, saturating (no wrap-around)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write_count <= '0;
    end else if (w_write_en && !w_cnt_sat) begin
      r_write_count <= r_write_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass.
  // Priority: x0 reads zero. A pending writeback to the same register forwards
  // result_w, but only while out of reset. Otherwise the stored value is read.
  // Reads are pure muxing of state, so an X address disturbs only the read
  // data and never the stored state.
  // ---------------------------------------------------------------------------
  function automatic logic [D_WIDTH-1:0] read_port(input logic [A_WIDTH-1:0] addr);
    logic [D_WIDTH-1:0] data;
    if (addr == '0) begin
      data = '0;
    end else if (rst_n && w_write_en && (rd_w == addr)) begin
      data = result_w;
    end else begin
      data = r_regs[addr];
    end
    return data;
  endfunction

  // NOTE: each combinational output gets a default first, then the overrides.
  // No path can leave it unassigned, so no latch is inferred.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    rd1_d = read_port(rs1_d);
    rd2_d = read_port(rs2_d);
  end

  assign a0          = r_a0;
  assign write_count = r_write_count;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Bench for register_file. The bench drives a table of one-cycle vectors on
// the falling edge of the clock. Each vector carries hand-derived expectations
// for the two combinational read ports.
//
// A reference model of the architectural state (registers, a0, write count)
// is updated at drive time. It pushes the expected post-edge a0 and count
// values into a queue. Those values are popped and compared one step after
// the rising edge.
//
// The counter-saturation corner case is reached by bulk writes to x1, followed
// by three checked writes at the saturation boundary.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          reg_write_w;
  logic [AW-1:0] rd_w;
  logic [DW-1:0] result_w;
  logic [AW-1:0] rs1_d;
  logic [AW-1:0] rs2_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic [DW-1:0] a0;
  logic [15:0]   write_count;

  register_file #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .result_w    (result_w),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd1_d       (rd1_d),
    .rd2_d       (rd2_d),
    .a0          (a0),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rstn;
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          chk_rd;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  typedef struct {
    logic [DW-1:0] a0;
    logic [15:0]   cnt;
  } post_t;

  int checks   = 0;
  int failures = 0;

  // Reference model of the architectural state
  logic [DW-1:0] m_regs [32];
  logic [15:0]   m_cnt;

  // Scoreboards
  logic [2*DW-1:0] q_rd   [$];
  post_t           q_post [$];

  vec_t vecs [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rstn, input logic we,
                              input logic [AW-1:0] rd, input logic [DW-1:0] data,
                              input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                              input logic chk_rd, input logic [DW-1:0] e1,
                              input logic [DW-1:0] e2);
    vec_t v;
    v.name = name; v.rstn = rstn; v.we = we; v.rd = rd; v.data = data;
    v.rs1 = rs1; v.rs2 = rs2; v.chk_rd = chk_rd; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  // Apply the model effect of one edge with the given inputs.
  task automatic model_edge(input logic rstn, input logic we, input logic [AW-1:0] rd,
                            input logic [DW-1:0] data);
    if (!rstn) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
    end else if (we && rd != '0) begin
      m_regs[rd] = data;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic drive(input vec_t v);
    logic [2*DW-1:0] rd_exp;
    post_t           p;
    @(negedge clk);
    rst_n       = v.rstn;
    reg_write_w = v.we;
    rd_w        = v.rd;
    result_w    = v.data;
    rs1_d       = v.rs1;
    rs2_d       = v.rs2;
    if (v.chk_rd) q_rd.push_back({v.e1, v.e2});
    model_edge(v.rstn, v.we, v.rd, v.data);
    q_post.push_back('{a0: m_regs[10], cnt: m_cnt});
    #1;
    if (v.chk_rd) begin
      rd_exp = q_rd.pop_front();
      check({v.name, ".rd1"}, rd1_d, rd_exp[2*DW-1:DW]);
      check({v.name, ".rd2"}, rd2_d, rd_exp[DW-1:0]);
    end
    @(posedge clk);
    #1;
    p = q_post.pop_front();
    check({v.name, ".a0"}, a0, p.a0);
    check({v.name, ".cnt"}, {16'h0, write_count}, {16'h0, p.cnt});
  endtask

  initial begin
    rst_n = 1'b0; reg_write_w = 1'b0; rd_w = '0; result_w = '0; rs1_d = '0; rs2_d = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;

    //        name            rstn we rd  data          rs1 rs2 chk e1            e2
    vecs.push_back(mk("reset",        0, 0, 0,  32'h0,        0,  0,  1, 32'h0,        32'h0));
    vecs.push_back(mk("wr_x5_bypass", 1, 1, 5,  32'hDEADBEEF, 5,  0,  1, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("rst_no_byp",   0, 1, 6,  32'h00001234, 5,  6,  1, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("flushed",      1, 0, 0,  32'h0,        5,  6,  1, 32'h0,        32'h0));
    vecs.push_back(mk("wr_x3",        1, 1, 3,  32'h7,        0,  0,  1, 32'h0,        32'h0));
    vecs.push_back(mk("basic_read",   1, 0, 0,  32'h0,        3,  0,  1, 32'h7,        32'h0));
    vecs.push_back(mk("x0_write",     1, 1, 0,  32'hFFFFFFFF, 0,  3,  1, 32'h0,        32'h7));
    vecs.push_back(mk("x0_read",      1, 0, 0,  32'h0,        0,  0,  1, 32'h0,        32'h0));
    vecs.push_back(mk("wr_x8_11",     1, 1, 8,  32'h11,       8,  8,  1, 32'h11,       32'h11));
    vecs.push_back(mk("bypass_both",  1, 1, 8,  32'h22,       8,  8,  1, 32'h22,       32'h22));
    vecs.push_back(mk("x8_stored",    1, 0, 8,  32'h0,        8,  3,  1, 32'h22,       32'h7));
    vecs.push_back(mk("wr_a0",        1, 1, 10, 32'hA5A5A5A5, 10, 0,  1, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk("wr_x11",       1, 1, 11, 32'h12345678, 10, 11, 1, 32'hA5A5A5A5, 32'h12345678));
    vecs.push_back(mk("rd_x11_x10",   1, 0, 0,  32'h0,        11, 10, 1, 32'h12345678, 32'hA5A5A5A5));
    vecs.push_back(mk("wr_x31",       1, 1, 31, 32'hFFFFFFFF, 31, 1,  1, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(mk("wr_x1",        1, 1, 1,  32'h80000001, 1,  31, 1, 32'h80000001, 32'hFFFFFFFF));
    vecs.push_back(mk("rst_mid",      0, 1, 2,  32'h0000AAAA, 1,  10, 1, 32'h80000001, 32'hA5A5A5A5));
    vecs.push_back(mk("first_after",  1, 1, 2,  32'h00005555, 2,  10, 1, 32'h00005555, 32'h0));
    vecs.push_back(mk("rd_after_rst", 1, 0, 0,  32'h0,        2,  1,  1, 32'h00005555, 32'h0));
    vecs.push_back(mk("x_addr_wr",    1, 1, 4,  32'h0000CAFE, 'x, 'x, 0, 32'h0,        32'h0));
    vecs.push_back(mk("x_addr_chk",   1, 0, 0,  32'h0,        4,  2,  1, 32'h0000CAFE, 32'h00005555));

    foreach (vecs[i]) drive(vecs[i]);

    // Bulk writes to x1 bring the counter to one below saturation.
    while (m_cnt != 16'hFFFE) begin
      @(negedge clk);
      rst_n = 1'b1; reg_write_w = 1'b1; rd_w = 5'd1; result_w = {16'h0, m_cnt};
      rs1_d = '0; rs2_d = '0;
      model_edge(1'b1, 1'b1, 5'd1, {16'h0, m_cnt});
    end
    @(posedge clk);
    #1;
    check("pre_sat.cnt", {16'h0, write_count}, 32'h0000FFFE);

    drive(mk("sat_wr1", 1, 1, 1, 32'h00000101, 1, 0, 1, 32'h00000101, 32'h0));
    drive(mk("sat_wr2", 1, 1, 1, 32'h00000202, 1, 0, 1, 32'h00000202, 32'h0));
    drive(mk("sat_wr3", 1, 1, 1, 32'h00000303, 1, 0, 1, 32'h00000303, 32'h0));
    drive(mk("sat_hold", 1, 0, 0, 32'h0, 1, 10, 1, 32'h00000303, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural integer register file for the 5-stage RISC-V pipeline.
- It receives the final result from the writeback stage and serves the two source-operand reads in decode.
- It provides write-through bypass, so a same-cycle writeback is visible to decode without a pipeline bubble.
- It exposes a registered copy of x10 (a0) for testbench and top-level observation.

Parameters:
- D_WIDTH, 32, data width of each register.
- A_WIDTH, 5, register address width; depth = 2**A_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- reg_write_w  input  1  write enable from writeback stage.
- rd_w  input  A_WIDTH  destination register address from writeback.
- result_w  input  D_WIDTH  data to write (writeback mux output).
- rs1_d  input  A_WIDTH  source 1 address from decode.
- rs2_d  input  A_WIDTH  source 2 address from decode.
- rd1_d  output  D_WIDTH  source 1 data (combinational).
- rd2_d  output  D_WIDTH  source 2 data (combinational).
- a0  output  D_WIDTH  registered value of x10.
- write_count  output  16  number of committed architectural writes (saturating).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset, sampled at a rising edge with rst_n=0:
  - all registers 0.
  - a0 = 0.
  - write_count = 0.
  - any write presented in that cycle is discarded (reset wins).
- Write, at a rising edge with rst_n=1, reg_write_w=1 and rd_w!=0:
  - regs[rd_w] <= result_w.
  - write_count increments by 1.
- x0 writes: with rd_w=0, the write is dropped and write_count is unchanged. x0 always reads 0.
- Reads: combinational, 0-cycle latency.
  - rd1_d = (rs1_d==0) ? 0 : (reg_write_w && rd_w==rs1_d) ? result_w : regs[rs1_d].
  - rd2_d follows the same rule on rs2_d.
  - Bypass is active only when rst_n=1. When rst_n=0, reads return stored data (0 after the reset edge).
- Port conflicts:
  - rs1_d==rs2_d==rd_w with a write pending: both read ports return result_w.
  - Concurrent reads never block writes.
- a0 register: a0 <= the post-write value of x10 each cycle.
  - A write to x10 at edge N appears on a0 after edge N (same edge as the array update).
  - a0 therefore always equals regs[10] one delta after the edge.
- write_count saturation: saturates at 16'hFFFF and holds. There is no wrap-around.
- Register data is not truncated or extended; writes store full D_WIDTH.
- Reset mid-stream: asserting rst_n=0 during back-to-back writes clears everything on that edge. The first write accepted is the one on the first edge with rst_n=1.
- Unknowns: X on rs1_d/rs2_d must not corrupt state. X on reg_write_w is a bench error; no requirement applies.
- Storage: flip-flop array. Single write port, two read ports plus the a0 tap. No latches.

Test Plan:
1. Reset flush:
   - Stimulus: write 0xDEADBEEF to x5, then hold rst_n=0 for one edge while presenting a write of 0x1234 to x6.
   - Required: x5=0, x6=0, a0=0, write_count=0.
2. Basic write/read:
   - Stimulus: write 0x00000007 to x3, then next cycle set rs1_d=3, rs2_d=0.
   - Required: rd1_d=7, rd2_d=0, write_count=1.
3. x0 immunity:
   - Stimulus: reg_write_w=1, rd_w=0, result_w=0xFFFFFFFF; then rs1_d=0.
   - Required: rd1_d=0, write_count unchanged.
4. Same-cycle bypass:
   - Stimulus: regs[8]=0x11; in one cycle drive reg_write_w=1, rd_w=8, result_w=0x22, rs1_d=8, rs2_d=8.
   - Required: rd1_d=rd2_d=0x22 before the edge; after the edge, regs[8] reads 0x22 with reg_write_w=0.
5. a0 tracking:
   - Stimulus: write 0xA5A5A5A5 to x10 at edge N.
   - Required: a0=0xA5A5A5A5 after edge N. A write to x11 leaves a0 unchanged.
6. Counter saturation:
   - Stimulus: force write_count to 0xFFFE, then issue 3 writes to x1.
   - Required: count reads 0xFFFF and holds.
